// File: rtl/flex_key_counter_pkg.sv
// Shared types and limits for the flex key-index counter (package key_cnt_pkg).
// The optional load feature is enabled by defining FLEX_KEY_COUNTER_LOAD_EN.
package key_cnt_pkg;

  typedef enum logic [1:0] {KC_IDLE, KC_COUNT, KC_DONE} key_cnt_state_t;

  localparam int KEY_CNT_MAX_BITS = 16;

endpackage

// File: rtl/flex_key_counter_if.sv
// Control/status bundle between the packet controller (master) and the key counter (slave).
// FLEX_KEY_COUNTER_LOAD_EN adds the load/load_val pair.
interface flex_key_counter_if
  import key_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) ();

  // No valid/ready here: clear, count_enable and load are per-cycle strobes sampled on every
  // rising edge, there is no backpressure, and every status output is registered.
  logic                    clear;
  logic                    count_enable;
  logic                    wrap_mode;
  logic [NUM_CNT_BITS-1:0] rollover_val;
`ifdef FLEX_KEY_COUNTER_LOAD_EN
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
`endif
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    wrap_pulse;
  logic                    done;
  key_cnt_state_t          state;

`ifdef FLEX_KEY_COUNTER_LOAD_EN
  modport master (
    output clear, count_enable, wrap_mode, rollover_val, load, load_val,
    input  count_out, rollover_flag, wrap_pulse, done, state
  );
  modport slave (
    input  clear, count_enable, wrap_mode, rollover_val, load, load_val,
    output count_out, rollover_flag, wrap_pulse, done, state
  );
`else
  modport master (
    output clear, count_enable, wrap_mode, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, done, state
  );
  modport slave (
    input  clear, count_enable, wrap_mode, rollover_val,
    output count_out, rollover_flag, wrap_pulse, done, state
  );
`endif

endinterface

// File: rtl/flex_key_counter.sv
// Key-slot counter: steps 0..rollover value, then wraps (cyclic) or parks in DONE (one-shot).
// Define FLEX_KEY_COUNTER_LOAD_EN to add a direct load of the slot index.
module flex_key_counter
  import key_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  flex_key_counter_if.slave        bus
);

  if (NUM_CNT_BITS < 1 || NUM_CNT_BITS > KEY_CNT_MAX_BITS) begin : g_bad_width
    $error("flex_key_counter: NUM_CNT_BITS out of range");
  end

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  key_cnt_state_t          state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] rv_q, rv_d;
  logic                    wrap_q, wrap_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic                    done_q, done_d;
  logic [NUM_CNT_BITS-1:0] rv_new;
  logic [NUM_CNT_BITS-1:0] count_inc;
`ifdef FLEX_KEY_COUNTER_LOAD_EN
  logic [NUM_CNT_BITS-1:0] rv_eff;
  logic                    wrap_eff;
  logic [NUM_CNT_BITS-1:0] load_cnt;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= KC_IDLE;
      count_q <= '0;
      rv_q    <= '1;
      wrap_q  <= 1'b0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rv_q    <= rv_d;
      wrap_q  <= wrap_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rv_d      = rv_q;
    wrap_d    = wrap_q;
    flag_d    = flag_q;
    pulse_d   = 1'b0;
    done_d    = done_q;
    // A zero rollover value would give a one-slot schedule; it means "use the full range".
    rv_new    = (bus.rollover_val == '0) ? '1 : bus.rollover_val;
    count_inc = count_q + CNT_ONE;
`ifdef FLEX_KEY_COUNTER_LOAD_EN
    rv_eff    = (state_q == KC_IDLE) ? rv_new : rv_q;
    wrap_eff  = (state_q == KC_IDLE) ? bus.wrap_mode : wrap_q;
    load_cnt  = (bus.load_val > rv_eff) ? rv_eff : bus.load_val;
`endif

    if (bus.clear) begin
      state_d = KC_IDLE;
      count_d = '0;
      flag_d  = 1'b0;
      done_d  = 1'b0;
`ifdef FLEX_KEY_COUNTER_LOAD_EN
    end else if (bus.load) begin
      rv_d    = rv_eff;
      wrap_d  = wrap_eff;
      count_d = load_cnt;
      flag_d  = (load_cnt == rv_eff);
      done_d  = !wrap_eff && (load_cnt == rv_eff);
      state_d = (!wrap_eff && (load_cnt == rv_eff)) ? KC_DONE : KC_COUNT;
`endif
    end else if (bus.count_enable) begin
      unique case (state_q)
        KC_IDLE: begin
          rv_d    = rv_new;
          wrap_d  = bus.wrap_mode;
          count_d = CNT_ONE;
          flag_d  = (rv_new == CNT_ONE);
          done_d  = !bus.wrap_mode && (rv_new == CNT_ONE);
          state_d = (!bus.wrap_mode && (rv_new == CNT_ONE)) ? KC_DONE : KC_COUNT;
        end
        KC_COUNT: begin
          if (count_q != rv_q) begin
            count_d = count_inc;
            flag_d  = (count_inc == rv_q);
            if (!wrap_q && (count_inc == rv_q)) begin
              done_d  = 1'b1;
              state_d = KC_DONE;
            end
          end else if (wrap_q) begin
            count_d = '0;
            flag_d  = 1'b0;
            pulse_d = 1'b1;
          end else begin
            // Only reachable if wrap_mode_q and the count ever disagree; park safely.
            done_d  = 1'b1;
            state_d = KC_DONE;
          end
        end
        KC_DONE: begin
        end
        default: begin
          state_d = KC_IDLE;
          count_d = '0;
          flag_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = pulse_q;
  assign bus.done          = done_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_flex_key_counter.sv
// Directed-vector bench for flex_key_counter (NUM_CNT_BITS=4); load vectors run only
// when FLEX_KEY_COUNTER_LOAD_EN is defined.
module tb_flex_key_counter;
  import key_cnt_pkg::*;

  logic clk;
  logic n_rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  flex_key_counter_if #(.NUM_CNT_BITS(4)) bus ();

  flex_key_counter #(.NUM_CNT_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int cnt, input int flag, input int pulse,
                           input int dn);
    check({tag, ".count"}, 32'(bus.count_out), cnt);
    check({tag, ".flag"},  32'(bus.rollover_flag), flag);
    check({tag, ".pulse"}, 32'(bus.wrap_pulse), pulse);
    check({tag, ".done"},  32'(bus.done), dn);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    bus.count_enable = 1'b0;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic enable_n(input int n);
    bus.count_enable = 1'b1;
    repeat (n) tick();
    bus.count_enable = 1'b0;
  endtask

  initial begin
    int flags_w[9];
    int pulse_w[9];
    n_rst            = 1'b0;
    bus.clear        = 1'b0;
    bus.count_enable = 1'b0;
    bus.wrap_mode    = 1'b1;
    bus.rollover_val = 4'd15;
`ifdef FLEX_KEY_COUNTER_LOAD_EN
    bus.load         = 1'b0;
    bus.load_val     = '0;
`endif
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0);
    check("reset.state", 32'(bus.state), 32'(KC_IDLE));
    n_rst = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset mid-count
    enable_n(5);
    check("t1.count5", 32'(bus.count_out), 5);
    #3 n_rst = 1'b0;
    #1;
    check_all("t1.async", 0, 0, 0, 0);
    check("t1.state", 32'(bus.state), 32'(KC_IDLE));
    @(negedge clk);
    n_rst = 1'b1;
    enable_n(1);
    check("t1.restart", 32'(bus.count_out), 1);

    // 2: cyclic wrap with rollover 3
    do_clear();
    bus.rollover_val = 4'd3;
    bus.wrap_mode    = 1'b1;
    exp_q   = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    flags_w = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    pulse_w = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    bus.count_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("t2.count[%0d]", i), 32'(bus.count_out), exp_q.pop_front());
      check($sformatf("t2.flag[%0d]", i), 32'(bus.rollover_flag), flags_w[i]);
      check($sformatf("t2.pulse[%0d]", i), 32'(bus.wrap_pulse), pulse_w[i]);
    end
    bus.count_enable = 1'b0;
    tick();
    check_all("t2.hold", 1, 0, 0, 0);

    // 3: one-shot stops at 5
    do_clear();
    bus.rollover_val = 4'd5;
    bus.wrap_mode    = 1'b0;
    bus.count_enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("t3.count[%0d]", i), 32'(bus.count_out), (i < 5) ? i : 5);
      check($sformatf("t3.done[%0d]", i), 32'(bus.done), (i >= 5) ? 1 : 0);
      check($sformatf("t3.flag[%0d]", i), 32'(bus.rollover_flag), (i >= 5) ? 1 : 0);
    end
    bus.count_enable = 1'b0;
    check("t3.state", 32'(bus.state), 32'(KC_DONE));

    // 4: late rollover change ignored; clear beats enable
    do_clear();
    check("t4.state_idle", 32'(bus.state), 32'(KC_IDLE));
    bus.rollover_val = 4'd5;
    bus.wrap_mode    = 1'b1;
    enable_n(2);
    check("t4.count2", 32'(bus.count_out), 2);
    bus.rollover_val = 4'd7;
    enable_n(3);
    check_all("t4.old_rv", 5, 1, 0, 0);
    bus.clear        = 1'b1;
    bus.count_enable = 1'b1;
    tick();
    bus.clear        = 1'b0;
    bus.count_enable = 1'b0;
    check_all("t4.clear", 0, 0, 0, 0);
    check("t4.clear_state", 32'(bus.state), 32'(KC_IDLE));
    enable_n(5);
    check_all("t4.new_rv5", 5, 0, 0, 0);
    enable_n(2);
    check_all("t4.new_rv7", 7, 1, 0, 0);
    enable_n(1);
    check_all("t4.wrap", 0, 0, 1, 0);

    // 5: edge rollover values
    do_clear();
    bus.rollover_val = 4'd0;
    bus.wrap_mode    = 1'b1;
    enable_n(15);
    check_all("t5.rv0_top", 15, 1, 0, 0);
    enable_n(1);
    check_all("t5.rv0_wrap", 0, 0, 1, 0);
    do_clear();
    bus.rollover_val = 4'd1;
    enable_n(1);
    check_all("t5.rv1_a", 1, 1, 0, 0);
    enable_n(1);
    check_all("t5.rv1_b", 0, 0, 1, 0);
    tick();
    check_all("t5.rv1_idle", 0, 0, 0, 0);
    enable_n(1);
    check_all("t5.rv1_c", 1, 1, 0, 0);
    enable_n(1);
    check_all("t5.rv1_d", 0, 0, 1, 0);

`ifdef FLEX_KEY_COUNTER_LOAD_EN
    // 6: load clamps to rollover value and beats count_enable
    do_clear();
    bus.rollover_val = 4'd6;
    bus.wrap_mode    = 1'b1;
    bus.load         = 1'b1;
    bus.load_val     = 4'd9;
    tick();
    check_all("t6.load_clamp", 6, 1, 0, 0);
    check("t6.state", 32'(bus.state), 32'(KC_COUNT));
    bus.load_val     = 4'd2;
    bus.count_enable = 1'b1;
    tick();
    bus.load         = 1'b0;
    bus.count_enable = 1'b0;
    check_all("t6.load_pri", 2, 0, 0, 0);
    do_clear();
    bus.wrap_mode    = 1'b0;
    bus.load         = 1'b1;
    bus.load_val     = 4'd6;
    tick();
    bus.load         = 1'b0;
    check_all("t6.oneshot", 6, 1, 0, 1);
    check("t6.done_state", 32'(bus.state), 32'(KC_DONE));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
